// File: rtl/core_mux_pkg.sv
// Shared definitions for the arbitrated register-mux: arbitration mode
// encodings and a width helper that never returns zero.
package core_mux_pkg;

    localparam logic ARB_RR    = 1'b1;
    localparam logic ARB_FIXED = 1'b0;

    // Index width for n entries, at least one bit so a single-entry
    // index still has a legal declaration.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage : core_mux_pkg

// File: rtl/arb_mux_reg_if.sv
// Producer/consumer bus of the arbitrated register-mux. The slave modport is
// the mux itself; the master modport is the producers plus the consumer.
interface arb_mux_reg_if
    import core_mux_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_CH   = 4,
    parameter int SEL_W  = clog2_min1(N_CH)
);

    logic [N_CH-1:0]   in_valid;
    logic [DATA_W-1:0] in_data [N_CH];
    logic [N_CH-1:0]   in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [SEL_W-1:0]  out_sel;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_sel
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_sel
    );

endinterface : arb_mux_reg_if

// File: rtl/arb_mux_reg_rr_arbiter.sv
// Combinational arbiter: picks one requester either by a round-robin scan
// starting at ptr (wrapping) or by lowest index. The caller owns ptr.
module rr_arbiter
    import core_mux_pkg::*;
#(
    parameter int   N_CH    = 4,
    parameter logic RR_MODE = ARB_RR,
    parameter int   SEL_W   = clog2_min1(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             en,
    output logic [N_CH-1:0]  gnt,
    output logic [SEL_W-1:0] gnt_idx
);

    logic [N_CH-1:0]  gnt_s;
    logic [SEL_W-1:0] gnt_idx_s;

    // base + off reduced into 0..N_CH-1; base is always in range so one
    // subtraction is enough.
    function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base,
                                                  input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_CH) begin
            s = s - N_CH;
        end else begin
            s = s;
        end
        return SEL_W'(s);
    endfunction

    // Scan candidates in priority order and keep the first valid one.
    always_comb begin
        logic             found;
        logic [SEL_W-1:0] cand;
        gnt_s     = '0;
        gnt_idx_s = '0;
        found     = 1'b0;
        cand      = '0;
        if (en) begin
            for (int k = 0; k < N_CH; k++) begin
                if (RR_MODE == ARB_RR) begin
                    cand = wrap_add(ptr, k);
                end else begin
                    cand = SEL_W'(k);
                end
                if (!found && req[cand]) begin
                    found       = 1'b1;
                    gnt_s[cand] = 1'b1;
                    gnt_idx_s   = cand;
                end else begin
                    found = found;
                end
            end
        end else begin
            gnt_s     = '0;
            gnt_idx_s = '0;
        end
    end

    assign gnt     = gnt_s;
    assign gnt_idx = gnt_idx_s;

endmodule : rr_arbiter

// File: rtl/arb_mux_reg.sv
// Registered N-to-1 mux with valid/ready per channel. Arbitration picks a
// winner whenever the output slot is free (empty or draining this cycle),
// so a full output register streams one beat per cycle.
module arb_mux_reg
    import core_mux_pkg::*;
#(
    parameter int   DATA_W  = 32,
    parameter int   N_CH    = 4,
    parameter logic RR_MODE = ARB_RR,
    parameter int   SEL_W   = clog2_min1(N_CH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_mux,
    arb_mux_reg_if.slave  bus
);

    if (N_CH < 2) begin : g_bad_n_ch
        $error("arb_mux_reg: N_CH must be at least 2");
    end

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0]  out_sel_q,   out_sel_d;
    logic [SEL_W-1:0]  ptr_q,       ptr_d;

    logic              slot_free_s;
    logic              arb_en_s;
    logic              grant_s;
    logic [N_CH-1:0]   gnt_s;
    logic [SEL_W-1:0]  gnt_idx_s;
    logic [DATA_W-1:0] mux_data_s;

    // Output slot can take a beat when empty or being drained this cycle;
    // reset holds off all grants so no handshake completes during it.
    always_comb begin
        slot_free_s = !out_valid_q || bus.out_ready;
        arb_en_s    = en_mux && slot_free_s && !rst;
    end

    rr_arbiter #(
        .N_CH    (N_CH),
        .RR_MODE (RR_MODE),
        .SEL_W   (SEL_W)
    ) u_arb (
        .req     (bus.in_valid),
        .ptr     (ptr_q),
        .en      (arb_en_s),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s)
    );

    // One-hot data select with an explicit zero when nothing is granted.
    always_comb begin
        grant_s    = |gnt_s;
        mux_data_s = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (gnt_s[k]) begin
                mux_data_s = bus.in_data[k];
            end else begin
                mux_data_s = mux_data_s;
            end
        end
    end

    // Next-state of the output register and the round-robin pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (grant_s) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_data_s;
            out_sel_d   = gnt_idx_s;
            if (RR_MODE == ARB_RR) begin
                if (gnt_idx_s == SEL_W'(N_CH - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = gnt_idx_s + SEL_W'(1);
                end
            end else begin
                ptr_d = ptr_q;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.in_ready  = gnt_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;

endmodule : arb_mux_reg
